rocketcpu_bus_master_arbiter: RTL and testbench

- Two-master Wishbone classic arbiter that shares the single memory bus between the CPU (master 0, ibus/dbus arbiter output) and a second master (master 1, e.g. a boot-loader or audio DMA engine).
- Grants masters round-robin and holds each grant for a whole transaction.
- A watchdog terminates any transaction that an address-decoded slave never acknowledges, so unmapped addresses no longer hang the core.
- Latches the offending address and raises a sticky flag that can feed the IRQ manager.

---
 rtl/rocketcpu_bus_master_arbiter.sv | 174 +++++++++++++++++
 tb/tb_rocketcpu_bus_master_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/rocketcpu_bus_master_arbiter.sv
// Two-master Wishbone classic arbiter with a transaction watchdog.
//
// Master 0 (CPU) and master 1 (e.g. boot loader or DMA) share one slave bus. The arbiter grants
// them round-robin and holds each grant for a whole transaction. A slave that never acknowledges
// is cut off after TIMEOUT cycles. The master then gets an error-style ack with all-ones data, and
// the offending address is latched behind a sticky flag.
//
// Ports:
//   i_wb_clk, reset         clock, asynchronous active-high reset
//   i_m0_* / o_m0_*         master 0 request (adr/dat/sel/we/cyc) and response (rdt/ack)
//   i_m1_* / o_m1_*         master 1 request and response
//   o_s_* / i_s_*           shared slave bus request and response
//   i_clr_timeout           one-cycle pulse that clears o_timeout
//   o_timeout               sticky flag, set when a transaction was forced to terminate
//   o_timeout_adr           address of the most recent timed-out transaction
module rocketcpu_bus_master_arbiter #(
  parameter int unsigned TIMEOUT = 255,  // 0 disables the watchdog
  parameter int unsigned CNT_W   = 8     // 2**CNT_W must exceed TIMEOUT
) (
  input  logic        i_wb_clk,
  input  logic        reset,
  input  logic [31:0] i_m0_adr,
  input  logic [31:0] i_m0_dat,
  input  logic [3:0]  i_m0_sel,
  input  logic        i_m0_we,
  input  logic        i_m0_cyc,
  output logic [31:0] o_m0_rdt,
  output logic        o_m0_ack,
  input  logic [31:0] i_m1_adr,
  input  logic [31:0] i_m1_dat,
  input  logic [3:0]  i_m1_sel,
  input  logic        i_m1_we,
  input  logic        i_m1_cyc,
  output logic [31:0] o_m1_rdt,
  output logic        o_m1_ack,
  output logic [31:0] o_s_adr,
  output logic [31:0] o_s_dat,
  output logic [3:0]  o_s_sel,
  output logic        o_s_we,
  output logic        o_s_cyc,
  input  logic [31:0] i_s_rdt,
  input  logic        i_s_ack,
  input  logic        i_clr_timeout,
  output logic        o_timeout,
  output logic [31:0] o_timeout_adr
);

  typedef enum logic [1:0] {StIdle, StBusy, StTerm} state_e;

  // Last BUSY cycle before termination is the one where cnt reaches TIMEOUT-1.
  localparam int unsigned TermCntInt = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam logic [CNT_W-1:0] TermCnt = TermCntInt[CNT_W-1:0];
  localparam bit WdogEn = (TIMEOUT != 0);

  state_e           state_q, state_d;
  logic             grant_q, grant_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
  logic [31:0]      timeout_adr_q, timeout_adr_d;

  // Request of the currently granted master.
  logic [31:0] g_adr, g_dat;
  logic [3:0]  g_sel;
  logic        g_we, g_cyc;

  always_comb begin
    g_adr = grant_q ? i_m1_adr : i_m0_adr;
    g_dat = grant_q ? i_m1_dat : i_m0_dat;
    g_sel = grant_q ? i_m1_sel : i_m0_sel;
    g_we  = grant_q ? i_m1_we  : i_m0_we;
    g_cyc = grant_q ? i_m1_cyc : i_m0_cyc;
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_d        = last_q;
    cnt_d         = cnt_q;
    timeout_d     = timeout_q;
    timeout_adr_d = timeout_adr_q;

    o_s_adr  = '0;
    o_s_dat  = '0;
    o_s_sel  = '0;
    o_s_we   = 1'b0;
    o_s_cyc  = 1'b0;
    o_m0_ack = 1'b0;
    o_m0_rdt = '0;
    o_m1_ack = 1'b0;
    o_m1_rdt = '0;

    // A termination in the same cycle overrides this below.
    if (i_clr_timeout) timeout_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (i_m0_cyc || i_m1_cyc) begin
          state_d = StBusy;
          cnt_d   = '0;
          if (i_m0_cyc && i_m1_cyc) grant_d = ~last_q;
          else                      grant_d = i_m1_cyc;
        end
      end

      StBusy: begin
        o_s_adr = g_adr;
        o_s_dat = g_dat;
        o_s_sel = g_sel;
        o_s_we  = g_we;
        o_s_cyc = g_cyc;
        if (grant_q) begin
          o_m1_ack = i_s_ack;
          o_m1_rdt = i_s_rdt;
        end else begin
          o_m0_ack = i_s_ack;
          o_m0_rdt = i_s_rdt;
        end

        if (i_s_ack || !g_cyc) begin
          // Completion or abort: either way the grant is released.
          last_d  = grant_q;
          cnt_d   = '0;
          state_d = StIdle;
        end else if (WdogEn && (cnt_q == TermCnt)) begin
          state_d = StTerm;
          cnt_d   = cnt_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StTerm: begin
        // Slave bus stays idle; any late slave ack is dropped.
        if (grant_q) begin
          o_m1_ack = 1'b1;
          o_m1_rdt = 32'hFFFF_FFFF;
        end else begin
          o_m0_ack = 1'b1;
          o_m0_rdt = 32'hFFFF_FFFF;
        end
        timeout_d     = 1'b1;
        timeout_adr_d = g_adr;
        last_d        = grant_q;
        cnt_d         = '0;
        state_d       = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_wb_clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      grant_q       <= 1'b0;
      last_q        <= 1'b1;  // master 0 wins the first tie
      cnt_q         <= '0;
      timeout_q     <= 1'b0;
      timeout_adr_q <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      last_q        <= last_d;
      cnt_q         <= cnt_d;
      timeout_q     <= timeout_d;
      timeout_adr_q <= timeout_adr_d;
    end
  end

  assign o_timeout     = timeout_q;
  assign o_timeout_adr = timeout_adr_q;

endmodule

// File: tb/tb_rocketcpu_bus_master_arbiter.sv
module tb_rocketcpu_bus_master_arbiter;

  logic        clk;
  logic        reset;
  logic [31:0] m0_adr, m0_dat, m1_adr, m1_dat, s_rdt;
  logic [3:0]  m0_sel, m1_sel;
  logic        m0_we, m0_cyc, m1_we, m1_cyc, s_ack, clr;
  logic [31:0] m0_rdt, m1_rdt, s_adr, s_dat, to_adr;
  logic [3:0]  s_sel;
  logic        m0_ack, m1_ack, s_we, s_cyc, to_flag;

  int checks = 0;
  int errors = 0;
  int hi;

  rocketcpu_bus_master_arbiter #(
    .TIMEOUT(255),
    .CNT_W  (8)
  ) dut (
    .i_wb_clk     (clk),
    .reset        (reset),
    .i_m0_adr     (m0_adr),
    .i_m0_dat     (m0_dat),
    .i_m0_sel     (m0_sel),
    .i_m0_we      (m0_we),
    .i_m0_cyc     (m0_cyc),
    .o_m0_rdt     (m0_rdt),
    .o_m0_ack     (m0_ack),
    .i_m1_adr     (m1_adr),
    .i_m1_dat     (m1_dat),
    .i_m1_sel     (m1_sel),
    .i_m1_we      (m1_we),
    .i_m1_cyc     (m1_cyc),
    .o_m1_rdt     (m1_rdt),
    .o_m1_ack     (m1_ack),
    .o_s_adr      (s_adr),
    .o_s_dat      (s_dat),
    .o_s_sel      (s_sel),
    .o_s_we       (s_we),
    .o_s_cyc      (s_cyc),
    .i_s_rdt      (s_rdt),
    .i_s_ack      (s_ack),
    .i_clr_timeout(clr),
    .o_timeout    (to_flag),
    .o_timeout_adr(to_adr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Move to 1 time unit after the next rising edge; inputs are driven here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset  = 1'b1;
    m0_adr = '0; m0_dat = '0; m0_sel = '0; m0_we = 1'b0; m0_cyc = 1'b0;
    m1_adr = '0; m1_dat = '0; m1_sel = '0; m1_we = 1'b0; m1_cyc = 1'b0;
    s_rdt  = '0; s_ack  = 1'b0; clr = 1'b0;
    #1;
    chk("rst_s_cyc", {31'd0, s_cyc}, 32'd0);
    chk("rst_s_adr", s_adr, 32'd0);
    chk("rst_m0_ack", {31'd0, m0_ack}, 32'd0);
    chk("rst_timeout", {31'd0, to_flag}, 32'd0);
    chk("rst_timeout_adr", to_adr, 32'd0);
    tick(); tick();
    reset = 1'b0;

    // Both masters request continuously, slave acks every cycle: m0 first, then alternate.
    m0_adr = 32'h0000_0100; m0_cyc = 1'b1;
    m1_adr = 32'h0000_0200; m1_cyc = 1'b1;
    s_ack = 1'b1; s_rdt = 32'h1111_2222;
    #1;
    chk("rr_idle0_s_cyc", {31'd0, s_cyc}, 32'd0);
    tick();
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_s_cyc", {31'd0, s_cyc}, 32'd1);
      chk("rr_s_adr", s_adr, (i % 2 == 0) ? 32'h0000_0100 : 32'h0000_0200);
      chk("rr_m0_ack", {31'd0, m0_ack}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("rr_m1_ack", {31'd0, m1_ack}, (i % 2 == 0) ? 32'd0 : 32'd1);
      tick();
      if (i == 3) begin
        m0_cyc = 1'b0; m1_cyc = 1'b0; s_ack = 1'b0;
      end
      #1;
      chk("rr_gap_s_cyc", {31'd0, s_cyc}, 32'd0);
      chk("rr_gap_m0_ack", {31'd0, m0_ack}, 32'd0);
      tick();
    end

    // Master 0 read, slave acks on the third bus cycle.
    m0_adr = 32'h0000_0010; m0_we = 1'b0; m0_sel = 4'hF; m0_cyc = 1'b1;
    #1;
    chk("rd_arb_s_cyc", {31'd0, s_cyc}, 32'd0);
    tick();
    #1;
    chk("rd_b1_s_cyc", {31'd0, s_cyc}, 32'd1);
    chk("rd_b1_s_adr", s_adr, 32'h0000_0010);
    chk("rd_b1_s_sel", {28'd0, s_sel}, 32'hF);
    chk("rd_b1_m0_ack", {31'd0, m0_ack}, 32'd0);
    tick();
    #1;
    chk("rd_b2_s_cyc", {31'd0, s_cyc}, 32'd1);
    chk("rd_b2_m0_ack", {31'd0, m0_ack}, 32'd0);
    tick();
    s_ack = 1'b1; s_rdt = 32'hDEAD_BEEF;
    #1;
    chk("rd_b3_s_cyc", {31'd0, s_cyc}, 32'd1);
    chk("rd_b3_m0_ack", {31'd0, m0_ack}, 32'd1);
    chk("rd_b3_m0_rdt", m0_rdt, 32'hDEAD_BEEF);
    chk("rd_b3_m1_ack", {31'd0, m1_ack}, 32'd0);
    chk("rd_b3_m1_rdt", m1_rdt, 32'd0);
    tick();
    m0_cyc = 1'b0; s_ack = 1'b0;
    #1;
    chk("rd_end_s_cyc", {31'd0, s_cyc}, 32'd0);
    chk("rd_end_m0_ack", {31'd0, m0_ack}, 32'd0);
    tick();

    // Master 1 write to an unmapped address: watchdog cuts it off after 255 cycles.
    m1_adr = 32'h0600_0000; m1_dat = 32'h1234_5678; m1_sel = 4'hF; m1_we = 1'b1; m1_cyc = 1'b1;
    tick();
    #1;
    chk("to_s_we", {31'd0, s_we}, 32'd1);
    chk("to_s_dat", s_dat, 32'h1234_5678);
    hi = 0;
    for (int i = 0; i < 255; i++) begin
      if (s_cyc && !m1_ack) hi++;
      tick();
      #1;
    end
    chk("to_busy_cycles", hi, 32'd255);
    s_ack = 1'b1; s_rdt = 32'h5555_5555;  // late ack must be ignored
    #1;
    chk("to_term_s_cyc", {31'd0, s_cyc}, 32'd0);
    chk("to_term_m1_ack", {31'd0, m1_ack}, 32'd1);
    chk("to_term_m1_rdt", m1_rdt, 32'hFFFF_FFFF);
    chk("to_term_m0_ack", {31'd0, m0_ack}, 32'd0);
    chk("to_term_flag_pre", {31'd0, to_flag}, 32'd0);
    tick();
    m1_cyc = 1'b0; m1_we = 1'b0; s_ack = 1'b0;
    #1;
    chk("to_flag", {31'd0, to_flag}, 32'd1);
    chk("to_adr", to_adr, 32'h0600_0000);
    chk("to_idle_m1_ack", {31'd0, m1_ack}, 32'd0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    #1;
    chk("to_clr_flag", {31'd0, to_flag}, 32'd0);
    chk("to_clr_adr_kept", to_adr, 32'h0600_0000);

    // Slave acks exactly on the last allowed cycle: normal completion.
    m0_adr = 32'h0000_0800; m0_cyc = 1'b1;
    tick();
    for (int i = 0; i < 254; i++) tick();
    s_ack = 1'b1; s_rdt = 32'hCAFE_F00D;
    #1;
    chk("edge_s_cyc", {31'd0, s_cyc}, 32'd1);
    chk("edge_m0_ack", {31'd0, m0_ack}, 32'd1);
    chk("edge_m0_rdt", m0_rdt, 32'hCAFE_F00D);
    tick();
    m0_cyc = 1'b0; s_ack = 1'b0;
    #1;
    chk("edge_next_m0_ack", {31'd0, m0_ack}, 32'd0);
    chk("edge_next_m0_rdt", m0_rdt, 32'd0);
    chk("edge_flag", {31'd0, to_flag}, 32'd0);
    tick();
    #1;
    chk("edge_flag_later", {31'd0, to_flag}, 32'd0);

    // Master 0 aborts on its third bus cycle while master 1 waits.
    m0_adr = 32'h0000_0300; m0_cyc = 1'b1;
    tick();
    m1_adr = 32'h0000_0400; m1_cyc = 1'b1; m1_we = 1'b0;
    #1;
    chk("ab_b1_s_adr", s_adr, 32'h0000_0300);
    tick();
    tick();
    m0_cyc = 1'b0;
    #1;
    chk("ab_b3_s_cyc", {31'd0, s_cyc}, 32'd0);
    chk("ab_b3_m0_ack", {31'd0, m0_ack}, 32'd0);
    tick();
    #1;
    chk("ab_idle_s_cyc", {31'd0, s_cyc}, 32'd0);
    chk("ab_idle_m0_ack", {31'd0, m0_ack}, 32'd0);
    tick();
    #1;
    chk("ab_m1_s_cyc", {31'd0, s_cyc}, 32'd1);
    chk("ab_m1_s_adr", s_adr, 32'h0000_0400);
    s_ack = 1'b1; s_rdt = 32'h0BAD_F00D;
    #1;
    chk("ab_m1_ack", {31'd0, m1_ack}, 32'd1);
    chk("ab_m0_ack", {31'd0, m0_ack}, 32'd0);
    tick();
    m1_cyc = 1'b0; s_ack = 1'b0;
    tick();

    // Reset in the middle of a master 0 transaction.
    m0_adr = 32'h0000_0500; m0_cyc = 1'b1;
    m1_adr = 32'h0000_0600; m1_cyc = 1'b1;
    tick();
    #1;
    chk("mr_busy_s_adr", s_adr, 32'h0000_0500);
    reset = 1'b1;
    #1;
    chk("mr_s_cyc", {31'd0, s_cyc}, 32'd0);
    chk("mr_s_adr", s_adr, 32'd0);
    chk("mr_s_we", {31'd0, s_we}, 32'd0);
    chk("mr_m0_ack", {31'd0, m0_ack}, 32'd0);
    chk("mr_m0_rdt", m0_rdt, 32'd0);
    tick();
    reset = 1'b0;
    #1;
    chk("mr_rel_s_cyc", {31'd0, s_cyc}, 32'd0);
    tick();
    #1;
    chk("mr_first_s_cyc", {31'd0, s_cyc}, 32'd1);
    chk("mr_first_s_adr", s_adr, 32'h0000_0500);
    m0_cyc = 1'b0; m1_cyc = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
